// File: rtl/debug_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debug_unit
// Purpose  : Host-side debug controller for the mips core. Decodes byte
//            commands from a UART receiver, loads programs into instruction
//            memory, runs or single-steps the core, and streams PC, register
//            bank and data memory back to the host.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid      received byte + one-cycle strobe
//   o_tx_data/o_tx_valid      byte to send, held until i_tx_ready
//   i_tx_ready                transmitter accepts when valid && ready
//   o_ins/o_ins_mem_wr        assembled instruction + write strobe
//   o_enable                  core pipeline enable
//   o_flush                   one-cycle pipeline flush
//   o_clear_program           one-cycle instruction-memory clear
//   i_end_program             core reached halt (level)
//   i_ins_mem_full            instruction memory full
//   i_registers/i_mem_data    flattened register bank / data memory
//   i_current_pc              core PC
//   o_state                   FSM state for observation
// Build option:
//   DEBUG_UNIT_ACK_EN         adds an ACK state that sends 8'h06 (ok) or
//                             8'h15 (load aborted, memory full) after LOAD,
//                             'R' and DUMP.
// Dump bytes assume 32-bit PC and data words (4 bytes each, little-endian).
// ============================================================================
module debug_unit #(
  parameter int INSTRUCTION_BUS_SIZE  = 32,
  parameter int DATA_BUS_SIZE         = 32,
  parameter int PC_BUS_SIZE           = 32,
  parameter int REGISTERS_BANK_SIZE   = 32,
  parameter int DATA_MEMORY_ADDR_SIZE = 5,
  parameter logic [INSTRUCTION_BUS_SIZE-1:0] HALT_INSTRUCTION = 32'hFC00_0000
) (
  input  logic                                                i_clk,
  input  logic                                                i_reset,
  input  logic [7:0]                                          i_rx_data,
  input  logic                                                i_rx_valid,
  output logic [7:0]                                          o_tx_data,
  output logic                                                o_tx_valid,
  input  logic                                                i_tx_ready,
  output logic [INSTRUCTION_BUS_SIZE-1:0]                     o_ins,
  output logic                                                o_ins_mem_wr,
  output logic                                                o_enable,
  output logic                                                o_flush,
  output logic                                                o_clear_program,
  input  logic                                                i_end_program,
  input  logic                                                i_ins_mem_full,
  input  logic [REGISTERS_BANK_SIZE*DATA_BUS_SIZE-1:0]        i_registers,
  input  logic [(2**DATA_MEMORY_ADDR_SIZE)*DATA_BUS_SIZE-1:0] i_mem_data,
  input  logic [PC_BUS_SIZE-1:0]                              i_current_pc,
  output logic [2:0]                                          o_state
);

  localparam int C_MEM_WORDS  = 2**DATA_MEMORY_ADDR_SIZE;
  localparam int C_DUMP_BYTES = 4 + 4*REGISTERS_BANK_SIZE + 4*C_MEM_WORDS;
  localparam int C_DUMP_BITS  = PC_BUS_SIZE + REGISTERS_BANK_SIZE*DATA_BUS_SIZE
                                + C_MEM_WORDS*DATA_BUS_SIZE;
  localparam int C_OFF_W      = $clog2(C_DUMP_BITS);
  // Byte index is sized so that {index, 3'b000} is exactly a bit offset.
  localparam int C_IDX_W      = C_OFF_W - 3;
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_DUMP_BYTES - 1);

  localparam logic [7:0] C_CMD_LOAD  = 8'h4C;
  localparam logic [7:0] C_CMD_RUN   = 8'h43;
  localparam logic [7:0] C_CMD_STEP  = 8'h53;
  localparam logic [7:0] C_CMD_RESET = 8'h52;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    DUMP = 3'd4
`ifdef DEBUG_UNIT_ACK_EN
    , ACK = 3'd5
`endif
  } state_t;

`ifdef DEBUG_UNIT_ACK_EN
  localparam state_t     C_DONE_STATE = ACK;
  localparam logic [7:0] C_ACK_OK     = 8'h06;
  localparam logic [7:0] C_ACK_NAK    = 8'h15;
  logic [7:0] r_ack_code;
`else
  localparam state_t     C_DONE_STATE = IDLE;
`endif

  state_t                          r_state;
  logic [1:0]                      r_byte_cnt;
  logic [INSTRUCTION_BUS_SIZE-9:0] r_shift;     // first three bytes of a word
  logic [C_IDX_W-1:0]              r_idx;       // byte currently presented
  logic [INSTRUCTION_BUS_SIZE-1:0] r_ins;
  logic                            r_ins_mem_wr;
  logic                            r_enable;
  logic                            r_flush;
  logic                            r_clear;
  logic [7:0]                      r_tx_data;
  logic                            r_tx_valid;

  logic [INSTRUCTION_BUS_SIZE-1:0] w_word;
  logic [C_DUMP_BITS-1:0]          w_dump_flat;
  logic [C_IDX_W-1:0]              w_sel_idx;
  logic [C_OFF_W-1:0]              w_bit_off;
  logic [7:0]                      w_sel_byte;

  assign w_word      = {r_shift, i_rx_data};
  assign w_dump_flat = {i_mem_data, i_registers, i_current_pc};
  // While a byte is on the bus, look ahead to the next one so an accepted
  // transfer can be followed immediately without a bubble cycle.
  assign w_sel_idx   = r_tx_valid ? (r_idx + C_IDX_W'(1)) : r_idx;
  assign w_bit_off   = {w_sel_idx, 3'b000};
  assign w_sel_byte  = w_dump_flat[w_bit_off +: 8];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_ins        <= '0;
      r_ins_mem_wr <= 1'b0;
      r_enable     <= 1'b0;
      r_flush      <= 1'b0;
      r_clear      <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
`ifdef DEBUG_UNIT_ACK_EN
      r_ack_code   <= '0;
`endif
    end else begin
      r_ins_mem_wr <= 1'b0;
      r_flush      <= 1'b0;
      r_clear      <= 1'b0;
      case (r_state)
        IDLE: begin
          r_enable <= 1'b0;
          if (i_rx_valid) begin
            case (i_rx_data)
              C_CMD_LOAD: begin
                r_clear    <= 1'b1;
                r_byte_cnt <= '0;
                r_state    <= LOAD;
              end
              C_CMD_RUN:  r_state <= RUN;
              C_CMD_STEP: r_state <= STEP;
              C_CMD_RESET: begin
                r_flush <= 1'b1;
`ifdef DEBUG_UNIT_ACK_EN
                r_ack_code <= C_ACK_OK;
`endif
                r_state <= C_DONE_STATE;
              end
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (i_rx_valid) begin
            r_shift    <= w_word[INSTRUCTION_BUS_SIZE-9:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (i_ins_mem_full) begin
`ifdef DEBUG_UNIT_ACK_EN
                r_ack_code <= C_ACK_NAK;
`endif
                r_state <= C_DONE_STATE;
              end else begin
                r_ins        <= w_word;
                r_ins_mem_wr <= 1'b1;
                if (w_word == HALT_INSTRUCTION) begin
`ifdef DEBUG_UNIT_ACK_EN
                  r_ack_code <= C_ACK_OK;
`endif
                  r_state <= C_DONE_STATE;
                end
              end
            end
          end
        end
        RUN: begin
          r_idx <= '0;
          if (i_end_program) begin
            r_enable <= 1'b0;
            r_state  <= DUMP;
          end else begin
            r_enable <= 1'b1;
          end
        end
        STEP: begin
          // Enable stays high through the first DUMP cycle only.
          r_idx    <= '0;
          r_enable <= ~i_end_program;
          r_state  <= DUMP;
        end
        DUMP: begin
          r_enable <= 1'b0;
          if (!r_tx_valid) begin
            r_tx_data  <= w_sel_byte;
            r_tx_valid <= 1'b1;
          end else if (i_tx_ready) begin
            if (r_idx == C_LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
`ifdef DEBUG_UNIT_ACK_EN
              r_ack_code <= C_ACK_OK;
`endif
              r_state <= C_DONE_STATE;
            end else begin
              r_idx     <= r_idx + C_IDX_W'(1);
              r_tx_data <= w_sel_byte;
            end
          end
        end
`ifdef DEBUG_UNIT_ACK_EN
        ACK: begin
          if (!r_tx_valid) begin
            r_tx_data  <= r_ack_code;
            r_tx_valid <= 1'b1;
          end else if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_state    <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;
  assign o_ins           = r_ins;
  assign o_ins_mem_wr    = r_ins_mem_wr;
  assign o_enable        = r_enable;
  assign o_flush         = r_flush;
  assign o_clear_program = r_clear;
  assign o_state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debug_unit
// Purpose  : Self-checking bench for debug_unit. A transaction-level model
//            predicts instruction writes, pulse counts and the byte stream the
//            host must receive; one monitor compares the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_unit;

  localparam int NREG       = 32;
  localparam int NMEM       = 32;
  localparam int DUMP_BYTES = 4 + 4*NREG + 4*NMEM;
  localparam logic [31:0] HALT = 32'hFC00_0000;
`ifdef DEBUG_UNIT_ACK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [31:0]       ins;
  logic              ins_mem_wr, enable, flush, clear_program;
  logic              end_program, ins_mem_full;
  logic [NREG*32-1:0] regs_flat;
  logic [NMEM*32-1:0] mem_flat;
  logic [31:0]       pc_val;
  logic [2:0]        state;

  logic [31:0] reg_val [NREG];
  logic [31:0] mem_val [NMEM];

  always #5 clk = ~clk;

  always_comb begin
    regs_flat = '0;
    mem_flat  = '0;
    for (int i = 0; i < NREG; i++) regs_flat[i*32 +: 32] = reg_val[i];
    for (int i = 0; i < NMEM; i++) mem_flat[i*32 +: 32]  = mem_val[i];
  end

  debug_unit dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .o_ins           (ins),
    .o_ins_mem_wr    (ins_mem_wr),
    .o_enable        (enable),
    .o_flush         (flush),
    .o_clear_program (clear_program),
    .i_end_program   (end_program),
    .i_ins_mem_full  (ins_mem_full),
    .i_registers     (regs_flat),
    .i_mem_data      (mem_flat),
    .i_current_pc    (pc_val),
    .o_state         (state)
  );

  // ---------------- model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ins[$];
  logic [31:0] got_ins[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] prog[$];
  logic [7:0]  got [DUMP_BYTES+4];
  int op_bytes = 0;
  int clear_cnt = 0, flush_cnt = 0, enable_cnt = 0;
  int exp_clear = 0, exp_flush = 0;
  int hold_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_ack(input logic [7:0] b);
    if (ACK_ON) exp_tx.push_back(b);
  endtask

  // Host-visible dump: PC, registers, memory, each word little-endian.
  task automatic push_dump();
    for (int b = 0; b < 4; b++) exp_tx.push_back(8'(pc_val >> (8*b)));
    for (int r = 0; r < NREG; r++)
      for (int b = 0; b < 4; b++) exp_tx.push_back(8'(reg_val[r] >> (8*b)));
    for (int m = 0; m < NMEM; m++)
      for (int b = 0; b < 4; b++) exp_tx.push_back(8'(mem_val[m] >> (8*b)));
    push_ack(8'h06);
  endtask

  task automatic randomize_core();
    pc_val = $urandom;
    for (int i = 0; i < NREG; i++) reg_val[i] = $urandom;
    for (int i = 0; i < NMEM; i++) mem_val[i] = $urandom;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       prev_v;
    logic [7:0] prev_d;
    logic       prev_acc;
    logic       acc;
    logic [31:0] ew;
    logic [7:0]  eb;
    prev_v = 1'b0; prev_d = '0; prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_acc = 1'b0;
      end else begin
        if (ins_mem_wr) begin
          got_ins.push_back(ins);
          check("ins write expected", 64'(exp_ins.size() != 0), 64'(1));
          if (exp_ins.size() != 0) begin
            ew = exp_ins.pop_front();
            check("ins word", 64'(ins), 64'(ew));
          end
        end
        if (clear_program) clear_cnt++;
        if (flush) flush_cnt++;
        if (enable) enable_cnt++;
        if (prev_v && !prev_acc) begin
          check("tx hold valid", 64'(tx_valid), 64'(1));
          check("tx hold data", 64'(tx_data), 64'(prev_d));
        end
        acc = tx_valid && tx_ready;
        if (acc) begin
          check("tx byte expected", 64'(exp_tx.size() != 0), 64'(1));
          if (exp_tx.size() != 0) begin
            eb = exp_tx.pop_front();
            check($sformatf("tx byte %0d", op_bytes), 64'(tx_data), 64'(eb));
          end
          if (op_bytes < DUMP_BYTES + 4) got[op_bytes] = tx_data;
          op_bytes++;
        end
        prev_v = tx_valid;
        prev_d = tx_data;
        prev_acc = acc;
      end
    end
  end

  // Transmitter readiness: random backpressure plus forced stalls.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (hold_n > 0) begin
        tx_ready = 1'b0;
        hold_n--;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #2;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state != 3'd0 && n < 5000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({name, " state"}, 64'(state), 64'(0));
    check({name, " ins queue empty"}, 64'(exp_ins.size()), 64'(0));
    check({name, " tx queue empty"}, 64'(exp_tx.size()), 64'(0));
    check({name, " clear count"}, 64'(clear_cnt), 64'(exp_clear));
    check({name, " flush count"}, 64'(flush_cnt), 64'(exp_flush));
  endtask

  // Load prog[]; full_at = index of the word during which memory reports full.
  task automatic do_load(input int full_at, input string name);
    logic [31:0] w;
    got_ins.delete();
    exp_clear++;
    for (int i = 0; i < prog.size(); i++) begin
      if (i == full_at) begin push_ack(8'h15); break; end
      exp_ins.push_back(prog[i]);
      if (prog[i] == HALT) begin push_ack(8'h06); break; end
    end
    send_byte(8'h4C, $urandom_range(0, 2));
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      if (i == full_at) ins_mem_full = 1'b1;
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], $urandom_range(0, 2));
      if (i == full_at || w == HALT) break;
    end
    ins_mem_full = 1'b0;
    wait_idle(name);
  endtask

  task automatic run_op(input int k_en, input string name);
    int base, k, n;
    bit injected;
    base = enable_cnt;
    push_dump();
    op_bytes = 0;
    if (k_en == 0) end_program = 1'b1;
    send_byte(8'h43, 0);
    k = 0; n = 0; injected = 1'b0;
    while (k_en > 0 && k < k_en && n < 1000) begin
      @(negedge clk); n++;
      if (enable) k++;
      if (k == 2 && !injected) begin
        rx_data = 8'h4C; rx_valid = 1'b1; injected = 1'b1;   // must be dropped
      end else begin
        rx_valid = 1'b0;
      end
    end
    rx_valid = 1'b0;
    end_program = 1'b1;
    wait_idle(name);
    end_program = 1'b0;
    check({name, " enable cycles in range"},
          64'((enable_cnt - base) >= k_en && (enable_cnt - base) <= k_en + 1), 64'(1));
    check({name, " byte total"}, 64'(op_bytes), 64'(DUMP_BYTES + (ACK_ON ? 1 : 0)));
  endtask

  task automatic step_op(input bit endp, input int hold_at, input string name);
    int base, n;
    base = enable_cnt;
    push_dump();
    op_bytes = 0;
    end_program = endp;
    send_byte(8'h53, 0);
    if (hold_at >= 0) begin
      n = 0;
      while (op_bytes < hold_at && n < 3000) begin @(negedge clk); n++; end
      hold_n = 5;
    end
    wait_idle(name);
    end_program = 1'b0;
    check({name, " enable cycles"}, 64'(enable_cnt - base), 64'(endp ? 0 : 1));
    check({name, " byte total"}, 64'(op_bytes), 64'(DUMP_BYTES + (ACK_ON ? 1 : 0)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, nw, fa;
    logic [31:0] w;
    logic [7:0]  b;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
    end_program = 1'b0; ins_mem_full = 1'b0;
    randomize_core();
    repeat (3) @(posedge clk); #2;
    check("reset state", 64'(state), 64'(0));
    check("reset ins", 64'(ins), 64'(0));
    check("reset outputs", 64'({ins_mem_wr, enable, flush, clear_program, tx_valid}), 64'(0));
    check("reset tx_data", 64'(tx_data), 64'(0));
    rst = 1'b0;

    // Program load ending in HALT.
    prog.delete(); prog.push_back(32'h2001_0005); prog.push_back(HALT);
    do_load(-1, "load");
    check("load writes", 64'(got_ins.size()), 64'(2));
    if (got_ins.size() == 2) begin
      check("load word0", 64'(got_ins[0]), 64'(32'h2001_0005));
      check("load word1", 64'(got_ins[1]), 64'(32'hFC00_0000));
    end

    // Memory full on the first word: nothing written.
    prog.delete(); prog.push_back(32'h1111_2222); prog.push_back(HALT);
    do_load(0, "load full");
    check("load full writes", 64'(got_ins.size()), 64'(0));

    // Random programs, sometimes hitting memory full part-way.
    repeat (4) begin
      nw = $urandom_range(1, 5);
      prog.delete();
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        prog.push_back(w);
      end
      prog.push_back(HALT);
      fa = ($urandom_range(0, 1) != 0) ? $urandom_range(0, nw) : -1;
      do_load(fa, "load rand");
    end

    // Non-command bytes are ignored.
    repeat (6) begin
      do b = 8'($urandom); while (b == 8'h4C || b == 8'h43 || b == 8'h53 || b == 8'h52);
      send_byte(b, $urandom_range(0, 2));
    end
    wait_idle("ignored");

    // Pipeline flush command.
    exp_flush++;
    push_ack(8'h06);
    send_byte(8'h52, 0);
    wait_idle("flush");

    // Run to halt after 10 enable cycles.
    randomize_core();
    pc_val = 32'h0000_0024;
    run_op(10, "run");
    check("run pc b0", 64'(got[0]), 64'(8'h24));
    check("run pc b1", 64'(got[1]), 64'(8'h00));
    check("run pc b2", 64'(got[2]), 64'(8'h00));
    check("run pc b3", 64'(got[3]), 64'(8'h00));

    // Run with the core already halted.
    randomize_core();
    run_op(0, "run halted");

    // Single step with a 5-cycle transmitter stall mid-dump.
    randomize_core();
    reg_val[1] = 32'h1234_5678;
    step_op(1'b0, 50, "step");
    check("step reg1 b0", 64'(got[8]),  64'(8'h78));
    check("step reg1 b1", 64'(got[9]),  64'(8'h56));
    check("step reg1 b2", 64'(got[10]), 64'(8'h34));
    check("step reg1 b3", 64'(got[11]), 64'(8'h12));

    // Step with the core halted: no enable pulse.
    randomize_core();
    step_op(1'b1, -1, "step halted");

    // Reset in the middle of a dump.
    randomize_core();
    push_dump();
    op_bytes = 0;
    send_byte(8'h53, 0);
    n = 0;
    while (op_bytes < 100 && n < 3000) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    check("midreset state", 64'(state), 64'(0));
    check("midreset outputs", 64'({ins_mem_wr, enable, flush, clear_program, tx_valid}), 64'(0));
    check("midreset tx_data", 64'(tx_data), 64'(0));
    check("midreset ins", 64'(ins), 64'(0));
    exp_tx.delete();
    exp_ins.delete();
    repeat (2) @(posedge clk); #2;
    rst = 1'b0;
    step_op(1'b0, -1, "step after reset");

    // A few random run/step operations.
    repeat (3) begin
      randomize_core();
      if ($urandom_range(0, 1) != 0) run_op($urandom_range(3, 20), "run rand");
      else step_op(1'b0, -1, "step rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
